// File: rtl/voxel_gpu_fill_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpu_pkg
// Description : Shared GPU types: fill-engine register indices, the fill FSM
//               state encoding and the camera/vector types used by the
//               renderer.
// Revision    : 1.0 - initial release
// ============================================================================
package gpu_pkg;

    // Register word indices on the s1 slave
    localparam logic [7:0] REG_PIXBUF  = 8'h00;
    localparam logic [7:0] REG_CLEAR   = 8'h01;
    localparam logic [7:0] REG_CTRL    = 8'h0d;
    localparam logic [7:0] REG_STATUS  = 8'h0e;
    localparam logic [7:0] REG_TRIGGER = 8'h0f;

    // Fill engine state encoding
    typedef enum logic [1:0] {
        FILL_IDLE   = 2'd0,
        FILL_WRITE  = 2'd1,
        FILL_FINISH = 2'd2
    } fill_state_e;

    // Renderer-side types
    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic signed [15:0] z;
    } vec3_t;

    typedef struct packed {
        vec3_t      pos;
        vec3_t      dir;
        logic [7:0] fov;
    } camera_t;

endpackage
`default_nettype wire

// File: rtl/voxel_gpu_fill_if.sv
`default_nettype none
// ============================================================================
// Module      : voxel_gpu_fill_if
// Description : Avalon-MM bundle for the fill block: the s1 register slave
//               and the m1 pixel-memory master.
// Revision    : 1.0 - initial release
// ============================================================================
interface voxel_gpu_fill_if;
    logic [7:0]  s1_address;
    logic [31:0] s1_writedata;
    logic        s1_write;
    logic [31:0] s1_readdata;
    logic        s1_waitrequest;
    logic [31:0] m1_address;
    logic [31:0] m1_writedata;
    logic        m1_write;
    logic        m1_waitrequest;
    logic        m1_read;
    logic [31:0] m1_readdata;
    logic        m1_readdatavalid;

    // Block side: register slave on s1, bus master on m1
    modport slave (
        input  s1_address, s1_writedata, s1_write,
        output s1_readdata, s1_waitrequest,
        output m1_address, m1_writedata, m1_write, m1_read,
        input  m1_waitrequest, m1_readdata, m1_readdatavalid
    );

    // System side: HPS bridge driving s1, memory answering m1
    modport master (
        output s1_address, s1_writedata, s1_write,
        input  s1_readdata, s1_waitrequest,
        input  m1_address, m1_writedata, m1_write, m1_read,
        output m1_waitrequest, m1_readdata, m1_readdatavalid
    );
endinterface
`default_nettype wire

// File: rtl/voxel_gpu_fill_dma.sv
`default_nettype none
// ============================================================================
// Module      : voxel_gpu_fill_dma
// Description : Frame-clear engine: fill FSM, row/column counters, address
//               generation and the m1 write handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module voxel_gpu_fill_dma
    import gpu_pkg::*;
#(
    parameter int H_RESOLUTION     = 256,
    parameter int V_RESOLUTION     = 192,
    parameter int PIXEL_BYTES      = 2,
    parameter int ROW_STRIDE_BYTES = 1024
) (
    input  wire logic        clock,
    input  wire logic        reset_n,
    input  wire logic        start,
    input  wire logic        abort_req,
    input  wire logic [31:0] base_in,
    input  wire logic [31:0] pat_in,
    input  wire logic        m1_waitrequest,
    output logic [31:0]      m1_address,
    output logic [31:0]      m1_writedata,
    output logic             m1_write,
    output logic             busy,
    output logic             finish
);

    localparam int c_WPR   = H_RESOLUTION * PIXEL_BYTES / 4;
    localparam int c_COL_W = (c_WPR > 1) ? $clog2(c_WPR) : 1;
    localparam int c_ROW_W = (V_RESOLUTION > 1) ? $clog2(V_RESOLUTION) : 1;
    localparam logic [c_COL_W-1:0] c_LAST_COL = c_COL_W'(c_WPR - 1);
    localparam logic [c_ROW_W-1:0] c_LAST_ROW = c_ROW_W'(V_RESOLUTION - 1);

    fill_state_e        r_state;
    fill_state_e        w_next_state;
    logic [31:0]        r_base;
    logic [31:0]        r_pat;
    logic [c_COL_W-1:0] r_col;
    logic [c_ROW_W-1:0] r_row;
    logic               r_abort_pend;

    logic        w_accept;
    logic        w_last;
    logic        w_abort;
    logic [31:0] w_addr;

    assign w_accept = (r_state == FILL_WRITE) && !m1_waitrequest;
    assign w_last   = (r_col == c_LAST_COL) && (r_row == c_LAST_ROW);
    // An abort seen in the same cycle as an acceptance still counts
    assign w_abort  = r_abort_pend || abort_req;
    assign w_addr   = r_base + (32'(r_row) * 32'(ROW_STRIDE_BYTES)) + (32'(r_col) << 2);

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) r_state <= FILL_IDLE;
        else          r_state <= w_next_state;
    end

    // Next-state: aborts only take effect on an accepted word
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            FILL_IDLE:   if (start) w_next_state = FILL_WRITE;
            FILL_WRITE: begin
                if (w_accept) begin
                    if (w_last)       w_next_state = FILL_FINISH;
                    else if (w_abort) w_next_state = FILL_IDLE;
                end
            end
            FILL_FINISH: w_next_state = FILL_IDLE;
            default:     w_next_state = FILL_IDLE;
        endcase
    end

    // Latched job parameters, word counters and pending abort flag
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_base       <= '0;
            r_pat        <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_abort_pend <= 1'b0;
        end else begin
            if (r_state == FILL_IDLE) begin
                r_abort_pend <= 1'b0;
                if (start) begin
                    r_base <= base_in;
                    r_pat  <= pat_in;
                    r_col  <= '0;
                    r_row  <= '0;
                end
            end else if (r_state == FILL_WRITE) begin
                if (abort_req) r_abort_pend <= 1'b1;
                if (w_accept) begin
                    if (r_col == c_LAST_COL) begin
                        r_col <= '0;
                        r_row <= r_row + 1'b1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
            end
        end
    end

    // Outputs: bus lines are zero whenever no word is being presented
    always_comb begin
        m1_write     = 1'b0;
        m1_address   = '0;
        m1_writedata = '0;
        busy         = (r_state != FILL_IDLE);
        finish       = (r_state == FILL_FINISH);
        if (r_state == FILL_WRITE) begin
            m1_write     = 1'b1;
            m1_address   = w_addr;
            m1_writedata = r_pat;
        end
    end

endmodule
`default_nettype wire

// File: rtl/voxel_gpu_fill.sv
`default_nettype none
// ============================================================================
// Module      : voxel_gpu_fill
// Description : GPU front end: Avalon-MM register file on s1, frame-clear DMA
//               on m1, level interrupt on fill completion.
// Revision    : 1.0 - initial release
// ============================================================================
module voxel_gpu_fill
    import gpu_pkg::*;
#(
    parameter logic [31:0] DEFAULT_BUFFER   = 32'h0800_0000,
    parameter int          H_RESOLUTION     = 256,
    parameter int          V_RESOLUTION     = 192,
    parameter int          PIXEL_BYTES      = 2,
    parameter int          ROW_STRIDE_BYTES = 1024
) (
    input  wire logic        clock,
    input  wire logic        reset_n,
    voxel_gpu_fill_if.slave  bus,
    output logic             irq
);

    logic [31:0] r_pixel_buffer;
    logic [31:0] r_clear_color;
    logic        r_irq_en;
    logic        r_done;

    logic w_busy;
    logic w_finish;
    logic w_wr_pixbuf;
    logic w_wr_clear;
    logic w_wr_ctrl;
    logic w_wr_status;
    logic w_wr_trigger;
    logic w_unused;

    assign w_wr_pixbuf  = bus.s1_write && (bus.s1_address == REG_PIXBUF);
    assign w_wr_clear   = bus.s1_write && (bus.s1_address == REG_CLEAR);
    assign w_wr_ctrl    = bus.s1_write && (bus.s1_address == REG_CTRL);
    assign w_wr_status  = bus.s1_write && (bus.s1_address == REG_STATUS);
    assign w_wr_trigger = bus.s1_write && (bus.s1_address == REG_TRIGGER);

    assign bus.s1_waitrequest = 1'b0;
    assign bus.m1_read        = 1'b0;
    assign w_unused           = ^{bus.m1_readdata, bus.m1_readdatavalid};

    // Register file; completion setting done beats a same-cycle W1C
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_pixel_buffer <= DEFAULT_BUFFER;
            r_clear_color  <= '0;
            r_irq_en       <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            if (w_wr_pixbuf) r_pixel_buffer <= bus.s1_writedata;
            if (w_wr_clear)  r_clear_color  <= bus.s1_writedata;
            if (w_wr_ctrl)   r_irq_en       <= bus.s1_writedata[0];
            if (w_finish)                                r_done <= 1'b1;
            else if (w_wr_status && bus.s1_writedata[1]) r_done <= 1'b0;
        end
    end

    // Combinational readback mux
    always_comb begin
        bus.s1_readdata = '0;
        case (bus.s1_address)
            REG_PIXBUF: bus.s1_readdata = r_pixel_buffer;
            REG_CLEAR:  bus.s1_readdata = r_clear_color;
            REG_CTRL:   bus.s1_readdata = {31'b0, r_irq_en};
            REG_STATUS: bus.s1_readdata = {30'b0, r_done, w_busy};
            default:    bus.s1_readdata = '0;
        endcase
    end

    assign irq = r_done && r_irq_en;

    voxel_gpu_fill_dma #(
        .H_RESOLUTION     (H_RESOLUTION),
        .V_RESOLUTION     (V_RESOLUTION),
        .PIXEL_BYTES      (PIXEL_BYTES),
        .ROW_STRIDE_BYTES (ROW_STRIDE_BYTES)
    ) u_dma (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (w_wr_trigger),
        .abort_req      (w_wr_status && bus.s1_writedata[2]),
        .base_in        (r_pixel_buffer),
        .pat_in         (r_clear_color),
        .m1_waitrequest (bus.m1_waitrequest),
        .m1_address     (bus.m1_address),
        .m1_writedata   (bus.m1_writedata),
        .m1_write       (bus.m1_write),
        .busy           (w_busy),
        .finish         (w_finish)
    );

endmodule
`default_nettype wire
